// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the CPU/DMA memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB_CPU = 1'b0,
    ARB_DMA = 1'b1
  } arb_state_t;

  localparam int QUANTUM_DEF   = 8;
  localparam int MAX_BURST_DEF = 16;

  // Counter width that stays at least one bit wide for a limit of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int QCNT_W_DEF = cnt_width(QUANTUM_DEF);
  localparam int BCNT_W_DEF = cnt_width(MAX_BURST_DEF);

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of the shared instruction/data memory.
// state   | meaning
// ARB_CPU | CPU owns memory (reset/park); qcnt counts contended cycles
// ARB_DMA | DMA owns memory; bcnt counts accepted beats of this grant
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int QUANTUM   = QUANTUM_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wd,
  output logic        cpu_ready,
  output logic [31:0] cpu_rd,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_adr,
  input  logic [31:0] dma_wd,
  input  logic        dma_last,
  output logic        dma_gnt,
  output logic [31:0] dma_rd,
  output logic [31:0] Adr,
  output logic [31:0] WriteData,
  output logic        MemWrite,
  input  logic [31:0] ReadData
);

  localparam int QW = cnt_width(QUANTUM);
  localparam int BW = cnt_width(MAX_BURST);
  localparam logic [QW-1:0] QLAST = QW'(QUANTUM - 1);
  localparam logic [BW-1:0] BLAST = BW'(MAX_BURST - 1);

  arb_state_t    state, state_nxt;
  logic [QW-1:0] qcnt, qcnt_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB_CPU;
      qcnt  <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      qcnt  <= qcnt_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    qcnt_nxt  = qcnt;
    bcnt_nxt  = bcnt;
    cpu_ready = 1'b1;
    dma_gnt   = 1'b0;
    Adr       = cpu_adr;
    WriteData = cpu_wd;
    MemWrite  = cpu_req & cpu_we;
    case (state)
      ARB_CPU: begin
        if (!dma_req) begin
          qcnt_nxt = '0;
        end else if (!cpu_req || qcnt == QLAST) begin
          state_nxt = ARB_DMA;
          qcnt_nxt  = '0;
          bcnt_nxt  = '0;
        end else begin
          qcnt_nxt = qcnt + QW'(1);
        end
      end
      ARB_DMA: begin
        cpu_ready = 1'b0;
        dma_gnt   = 1'b1;
        Adr       = dma_adr;
        WriteData = dma_wd;
        MemWrite  = dma_req & dma_we;
        if (!dma_req || dma_last) begin
          state_nxt = ARB_CPU;
          bcnt_nxt  = '0;
        end else if (bcnt == BLAST) begin
          // Burst limit: keep the grant only if the CPU has nothing to do.
          bcnt_nxt = '0;
          if (cpu_req) state_nxt = ARB_CPU;
        end else begin
          bcnt_nxt = bcnt + BW'(1);
        end
      end
      default: state_nxt = ARB_CPU;
    endcase
  end

  assign cpu_rd = ReadData;
  assign dma_rd = ReadData;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against an ownership/memory model.
module tb_mem_arbiter;

  localparam int Q  = 8;
  localparam int MB = 16;

  logic        clk, reset;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_last;
  logic [31:0] cpu_adr, cpu_wd, dma_adr, dma_wd;
  logic        cpu_ready, dma_gnt, MemWrite;
  logic [31:0] cpu_rd, dma_rd, Adr, WriteData, ReadData;

  mem_arbiter #(.QUANTUM(Q), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
    .cpu_ready(cpu_ready), .cpu_rd(cpu_rd),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wd(dma_wd),
    .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rd(dma_rd),
    .Adr(Adr), .WriteData(WriteData), .MemWrite(MemWrite), .ReadData(ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the arbiter's pins.
  logic [31:0] mem [256];
  bit          clr;
  assign ReadData = mem[Adr[9:2]];
  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 256; k++) mem[k] <= '0;
    end else if (MemWrite) begin
      mem[Adr[9:2]] <= WriteData;
    end
  end

  // Reference: who owns memory, plus what memory should contain.
  bit          m_dma;
  int          m_hold;   // contended cycles the CPU has kept memory from a waiting DMA
  int          m_beats;  // beats granted in the current DMA burst
  logic [31:0] ref_mem [256];
  bit          last_acc, last_gnt;

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [31:0] ea, ew;
    logic        emw;
    bit          r, dq, cq, dl;
    if (reset) begin
      m_dma = 1'b0; m_hold = 0; m_beats = 0;
    end
    #1;
    ea  = m_dma ? dma_adr : cpu_adr;
    ew  = m_dma ? dma_wd  : cpu_wd;
    emw = m_dma ? (dma_req & dma_we) : (cpu_req & cpu_we);
    chk("cpu_ready", {31'b0, cpu_ready}, {31'b0, !m_dma});
    chk("dma_gnt",   {31'b0, dma_gnt},   {31'b0, m_dma});
    chk("adr",       Adr,                ea);
    chk("wdata",     WriteData,          ew);
    chk("memwrite",  {31'b0, MemWrite},  {31'b0, emw});
    chk("cpu_rd",    cpu_rd,             ref_mem[ea[9:2]]);
    chk("dma_rd",    dma_rd,             ref_mem[ea[9:2]]);
    last_gnt = dma_gnt;
    last_acc = m_dma && dma_req;
    r = reset; dq = dma_req; cq = cpu_req; dl = dma_last;
    @(posedge clk);
    if (emw) ref_mem[ea[9:2]] = ew;
    if (!r) begin
      if (!m_dma) begin
        if (dq && cq) begin
          if (m_hold == Q - 1) begin m_dma = 1'b1; m_hold = 0; m_beats = 0; end
          else m_hold++;
        end else if (dq) begin
          m_dma = 1'b1; m_hold = 0; m_beats = 0;
        end else begin
          m_hold = 0;
        end
      end else begin
        if (!dq || dl) begin
          m_dma = 1'b0; m_beats = 0;
        end else if (m_beats == MB - 1) begin
          m_beats = 0;
          if (cq) m_dma = 1'b0;
        end else begin
          m_beats++;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int n, cyc, first;
    bit broke, dma_act;
    logic [31:0] base;

    reset = 1'b1; clr = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_wd = '0;
    dma_req = 0; dma_we = 0; dma_adr = '0; dma_wd = '0; dma_last = 0;
    m_dma = 0; m_hold = 0; m_beats = 0;
    for (int k = 0; k < 256; k++) ref_mem[k] = '0;

    // Reset holds the CPU as owner even with DMA requesting.
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_adr = 32'h40; cpu_wd = 32'hDEADBEEF; dma_req = 1;
    #1;
    chk("rst_cpu_ready", {31'b0, cpu_ready}, 32'd1);
    chk("rst_dma_gnt",   {31'b0, dma_gnt},   32'd0);
    chk("rst_memwrite",  {31'b0, MemWrite},  32'd1);
    chk("rst_adr",       Adr,                32'h40);
    clr = 1'b0; reset = 1'b0; dma_req = 0;

    // CPU write then readback with zero latency.
    cycle();
    cpu_we = 0;
    #1 chk("rd_40", cpu_rd, 32'hDEADBEEF);
    cycle();

    // Four-beat DMA burst with CPU idle.
    cpu_req = 0; dma_we = 1; n = 0; cyc = 0;
    while (n < 4 && cyc < 20) begin
      dma_req = 1; dma_adr = 32'h100 + 32'(4 * n); dma_wd = 32'hC0DE0000 + 32'(n);
      dma_last = (n == 3);
      cycle();
      if (last_acc) n++;
      cyc++;
    end
    chk("dma4_beats", 32'(n), 32'd4);
    chk("dma4_cycles", 32'(cyc), 32'd5);
    dma_req = 0; dma_last = 0; dma_we = 0;
    cpu_req = 1; cpu_adr = 32'h10C;
    #1 chk("dma4_release", {31'b0, dma_gnt}, 32'd0);
    chk("dma4_rd10c", cpu_rd, 32'hC0DE0003);
    cycle();

    // Sustained contention: 8 CPU cycles, 16 DMA beats, repeating.
    cpu_req = 1; cpu_adr = 32'h104; dma_req = 1; dma_adr = 32'h108; dma_last = 0;
    for (int i = 0; i < 48; i++) begin
      cycle();
      chk("contend_pattern", {31'b0, last_gnt}, {31'b0, ((i % 24) >= 8)});
    end
    dma_req = 0; cpu_req = 0;
    cycle();

    // 20 beats with CPU idle: no gap at the burst limit.
    dma_we = 1; n = 0; cyc = 0;
    while (n < 20 && cyc < 60) begin
      dma_req = 1; dma_adr = 32'h180 + 32'(4 * n); dma_wd = 32'h5A000000 + 32'(n);
      cycle();
      if (last_acc) n++;
      cyc++;
    end
    chk("burst20_beats", 32'(n), 32'd20);
    chk("burst20_cycles", 32'(cyc), 32'd21);
    dma_req = 0;
    cycle();

    // 20 beats with the CPU waiting from beat 3.
    n = 0; cyc = 0; first = 0; broke = 0;
    while (n < 20 && cyc < 80) begin
      cpu_req = (n >= 2); cpu_adr = 32'h184;
      dma_req = 1; dma_adr = 32'h1C0 + 32'(4 * n); dma_wd = 32'h6B000000 + 32'(n);
      cycle();
      if (!last_gnt && n > 0) broke = 1;
      if (last_acc) begin
        n++;
        if (!broke) first++;
      end
      cyc++;
    end
    chk("burstw_first", 32'(first), 32'd16);
    chk("burstw_cycles", 32'(cyc), 32'd29);
    dma_req = 0; cpu_req = 0;
    cycle();

    // Reset during beat 5 of a write burst.
    dma_we = 1; n = 0; cyc = 0;
    while (n < 4 && cyc < 20) begin
      dma_req = 1; dma_adr = 32'h200 + 32'(4 * n); dma_wd = 32'hA5000000 + 32'(n);
      cycle();
      if (last_acc) n++;
      cyc++;
    end
    dma_adr = 32'h210; dma_wd = 32'hA5000004;
    reset = 1; cpu_req = 1; cpu_we = 1; cpu_adr = 32'h300; cpu_wd = 32'h0BADF00D;
    #1;
    chk("rstmid_dma_gnt",   {31'b0, dma_gnt},   32'd0);
    chk("rstmid_cpu_ready", {31'b0, cpu_ready}, 32'd1);
    chk("rstmid_memwrite",  {31'b0, MemWrite},  32'd1);
    chk("rstmid_adr",       Adr,                32'h300);
    cycle();
    reset = 0; dma_req = 0; cpu_we = 0; cpu_adr = 32'h210;
    #1 chk("rstmid_dropped", cpu_rd, 32'h0);
    cycle();
    cpu_adr = 32'h300;
    #1 chk("rstmid_cpu_wr", cpu_rd, 32'h0BADF00D);
    cycle();

    // Randomized traffic, including occasional resets.
    dma_act = 0; n = 0; base = '0;
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 249) == 0);
      if (!dma_act && $urandom_range(0, 5) == 0) begin
        dma_act = 1; base = $urandom; n = 0;
      end
      dma_req  = dma_act;
      dma_we   = 1'($urandom_range(0, 1));
      dma_adr  = base + 32'(4 * n);
      dma_wd   = $urandom;
      dma_last = dma_act && ($urandom_range(0, 7) == 0);
      cpu_req  = ($urandom_range(0, 3) != 0);
      cpu_we   = 1'($urandom_range(0, 1));
      cpu_adr  = $urandom;
      cpu_wd   = $urandom;
      cycle();
      if (last_acc) begin
        n++;
        if (dma_last) dma_act = 0;
      end else if (dma_act && $urandom_range(0, 19) == 0) begin
        dma_act = 0;
      end
    end
    reset = 0; dma_req = 0; dma_last = 0;

    // Readback of every word.
    cpu_req = 1; cpu_we = 0;
    for (int i = 0; i < 256; i++) begin
      cpu_adr = 32'(i * 4);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
